// File: rtl/csa_resolve_pipe.sv
// csa_resolve_pipe
//   Resolves the carry-save pair left by the 5:3 compressor tree into a binary
//   result. It uses a two-stage split carry-propagate adder. Stage 1 adds the
//   low LO bits. Stage 2 adds the high slices plus the low-half carry-out.
//   Valid/ready handshaking is used on both sides, with throughput of one beat
//   per cycle and a latency of two cycles.
//
//   Optional feature: define CSA_RESOLVE_ACC_EN to accumulate resolved values
//   over a group of beats. Only the beat carrying in_last produces an output,
//   and that output is the group total, wrapped modulo 2^RW.
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   upstream beat present
//     in_ready   out  stage can accept a beat this cycle
//     in_sum     in   [W-1:0] sum vector, bit i weight 2^i
//     in_carry   in   [W-1:0] carry vector, bit i weight 2^(i+1)
//     in_last    in   final beat of a group (accumulate build only)
//     out_valid  out  result valid
//     out_ready  in   downstream accepts the result
//     out_result out  [RW-1:0] in_sum + (in_carry << 1), zero-extended
module csa_resolve_pipe #(
  parameter int  W     = 16,
  parameter int  LO    = W / 2,
  parameter int  ACC_G = 6,
  localparam int RW    = W + 2 + ACC_G
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_sum,
  input  logic [W-1:0]  in_carry,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_result
);

  localparam int HI = W - LO;

  // Handshake
  logic adv;
  logic accept;

  // Stage 1 registers
  logic          s1_valid_q, s1_valid_d;
  logic [LO-1:0] s1_lo_q,    s1_lo_d;
  logic          s1_c_q,     s1_c_d;
  logic [HI-1:0] s1_a_hi_q,  s1_a_hi_d;
  logic [HI:0]   s1_b_hi_q,  s1_b_hi_d;

  // Stage 2 registers
  logic          out_valid_q,  out_valid_d;
  logic [RW-1:0] out_result_q, out_result_d;

  // Arithmetic
  logic [LO:0]   lo_add;
  logic [HI+1:0] hi_add;
  logic [W+1:0]  s2_value;

`ifdef CSA_RESOLVE_ACC_EN
  logic          s1_last_q, s1_last_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] acc_sum;
`else
  logic          unused_last;
  assign unused_last = in_last;
`endif

  // The pipeline advances whenever stage 2 is empty or is being drained.
  // An empty stage 1 still accepts a beat while the output is stalled.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv || !s1_valid_q;
  assign accept   = in_valid && in_ready;

  // Low half. The shifted carry vector contributes in_carry[LO-2:0] above a
  // zero LSB. in_carry[W-1:LO-1] becomes the high operand, which is one bit
  // wider than the sum slice.
  assign lo_add = {1'b0, in_sum[LO-1:0]} + {1'b0, in_carry[LO-2:0], 1'b0};

  // High half. The largest value is 3*2^HI - 1, which fits in HI+2 bits.
  assign hi_add   = {2'b00, s1_a_hi_q} + {1'b0, s1_b_hi_q} + {{(HI+1){1'b0}}, s1_c_q};
  assign s2_value = {hi_add, s1_lo_q};

`ifdef CSA_RESOLVE_ACC_EN
  assign acc_sum = acc_q + {{ACC_G{1'b0}}, s2_value};
`endif

  // NOTE: every always_comb output gets its hold value first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c_d     = s1_c_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_b_hi_d  = s1_b_hi_q;
`ifdef CSA_RESOLVE_ACC_EN
    s1_last_d  = s1_last_q;
`endif
    // Data loads only on acceptance, so X on idle inputs never enters state.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = lo_add[LO-1:0];
      s1_c_d     = lo_add[LO];
      s1_a_hi_d  = in_sum[W-1:LO];
      s1_b_hi_d  = in_carry[W-1:LO-1];
`ifdef CSA_RESOLVE_ACC_EN
      s1_last_d  = in_last;
`endif
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
`ifdef CSA_RESOLVE_ACC_EN
    acc_d        = acc_q;
`endif
    if (adv) begin
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
`ifdef CSA_RESOLVE_ACC_EN
        // Clearing the accumulator after a last beat makes the next beat a
        // fresh load. An update only happens on adv, so a stall never
        // double-counts a beat.
        if (s1_last_q) begin
          out_valid_d  = 1'b1;
          out_result_d = acc_sum;
          acc_d        = '0;
        end else begin
          acc_d        = acc_sum;
        end
`else
        out_valid_d  = 1'b1;
        out_result_d = {{ACC_G{1'b0}}, s2_value};
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_lo_q      <= '0;
      s1_c_q       <= 1'b0;
      s1_a_hi_q    <= '0;
      s1_b_hi_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifdef CSA_RESOLVE_ACC_EN
      s1_last_q    <= 1'b0;
      acc_q        <= '0;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_lo_q      <= s1_lo_d;
      s1_c_q       <= s1_c_d;
      s1_a_hi_q    <= s1_a_hi_d;
      s1_b_hi_q    <= s1_b_hi_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
`ifdef CSA_RESOLVE_ACC_EN
      s1_last_q    <= s1_last_d;
      acc_q        <= acc_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Testbench for csa_resolve_pipe.
// Uses directed vectors with hand-computed expected values.
// Each task drives one scenario and samples outputs 1 time unit after the
// rising edge. The run ends with a single summary line.
module tb_csa_resolve_pipe;

  localparam int W  = 16;
  localparam int RW = W + 2 + 6;
`ifdef CSA_RESOLVE_ACC_EN
  localparam bit ACC_BUILD = 1'b1;
`else
  localparam bit ACC_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sum;
  logic [W-1:0]  in_carry;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csa_resolve_pipe #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sum   = 'x;
    in_carry = 'x;
    in_last  = 'x;
  endtask

  // Sends one beat with out_ready high and checks the two-cycle latency and
  // the one-cycle valid pulse. Idle inputs are X so that leakage shows up.
  task automatic do_beat(input string name, input logic [W-1:0] s,
                         input logic [W-1:0] c, input logic [RW-1:0] exp);
    in_sum = s; in_carry = c; in_valid = 1'b1; in_last = ACC_BUILD;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== exp) begin
      errors++;
      $display("FAIL %s_result: got valid=%b result=%h want valid=1 result=%h",
               name, out_valid, out_result, exp);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_pulse: got valid=%b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; idle_inputs();
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b result=%h want 0/0", out_valid, out_result);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    do_beat("basic", 16'h0005, 16'h0003, 24'h00000B);
  endtask

  task automatic test_boundaries();
    do_beat("cross_half", 16'h00FF, 16'h0001, 24'h000101);
    do_beat("all_ones",   16'hFFFF, 16'hFFFF, 24'h02FFFD);
    do_beat("all_zeros",  16'h0000, 16'h0000, 24'h000000);
    do_beat("high_only",  16'hFF00, 16'h8000, 24'h01FF00);
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp [4];
    exp[0] = 24'd3; exp[1] = 24'd6; exp[2] = 24'd9; exp[3] = 24'd12;
    out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      checks++;
      if (t >= 2 && t < 6) begin
        if (out_valid !== 1'b1 || out_result !== exp[t-2]) begin
          errors++;
          $display("FAIL stream_out%0d: got valid=%b result=%h want valid=1 result=%h",
                   t - 2, out_valid, out_result, exp[t-2]);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stream_idle%0d: got valid=%b want 0", t, out_valid);
      end
      if (t < 4) begin
        in_valid = 1'b1;
        in_sum   = W'(t + 1);
        in_carry = W'(t + 1);
        // in_last is ignored in the default build, so it toggles here.
        in_last  = ACC_BUILD ? 1'b1 : t[0];
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_ready%0d: got %b want 1", t, in_ready);
        end
      end else begin
        idle_inputs();
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    // c0: beat A = 7
    in_valid = 1'b1; in_sum = 16'h0007; in_carry = 16'h0000; in_last = ACC_BUILD;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b want 1", in_ready); end
    tick();
    // c1: beat B = 16
    in_sum = 16'h0000; in_carry = 16'h0008;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_c1: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    tick();
    // c2, c3: beat C = 0x10000 is offered but both stages are full
    in_sum = 16'h8000; in_carry = 16'h4000;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 24'd7) begin
        errors++;
        $display("FAIL bp_stall%0d: got in_ready=%b valid=%b result=%h want 0/1/000007",
                 k, in_ready, out_valid, out_result);
      end
      tick();
    end
    // c4: the release consumes A and accepts C in the same cycle
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_result !== 24'd7) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b result=%h want 1/000007", in_ready, out_result);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 24'd16) begin
      errors++; $display("FAIL bp_out_b: got valid=%b result=%h want 1/000010", out_valid, out_result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 24'h010000) begin
      errors++; $display("FAIL bp_out_c: got valid=%b result=%h want 1/010000", out_valid, out_result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 16'h0011; in_carry = 16'h0000; in_last = ACC_BUILD;
    tick();
    in_sum = 16'h0022;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 24'h000011) begin
      errors++; $display("FAIL rst_mid_pre: got valid=%b result=%h want 1/000011", out_valid, out_result);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0) begin
      errors++; $display("FAIL rst_mid_async: got valid=%b result=%h want 0/0", out_valid, out_result);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_stale%0d: got valid=%b in_ready=%b want 0/1", k, out_valid, in_ready);
      end
    end
    do_beat("rst_mid_fresh", 16'h1234, 16'h0101, 24'h001436);
  endtask

`ifdef CSA_RESOLVE_ACC_EN
  task automatic test_acc();
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      checks++;
      if (t == 4) begin
        if (out_valid !== 1'b1 || out_result !== 24'd60) begin
          errors++; $display("FAIL acc_total: got valid=%b result=%h want 1/00003c", out_valid, out_result);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL acc_quiet%0d: got valid=%b want 0", t, out_valid);
      end
      if (t < 3) begin
        in_valid = 1'b1; in_sum = W'(10 * (t + 1)); in_carry = 16'h0000; in_last = (t == 2);
      end else begin
        idle_inputs();
      end
      tick();
    end
    do_beat("acc_fresh", 16'h0005, 16'h0001, 24'd7);
  endtask
`endif

  initial begin
    idle_inputs();
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef CSA_RESOLVE_ACC_EN
    test_acc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
